imem_load_ctrl: RTL and testbench



---
 rtl/imem_load_ctrl_if.sv | 23 ++
 rtl/imem_load_ctrl.sv | 108 ++++++++++
 tb/tb_imem_load_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_load_ctrl_if.sv
// AXI4-Lite write-only channel bundle between the SoC interconnect and the imem loader.
interface imem_load_ctrl_if;
  logic        s_awvalid;
  logic        s_awready;
  logic [10:0] s_awaddr;
  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid;
  logic        s_bready;
  logic [1:0]  s_bresp;

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    input  s_awready, s_wready, s_bvalid, s_bresp
  );

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
    output s_awready, s_wready, s_bvalid, s_bresp
  );
endinterface

// File: rtl/imem_load_ctrl.sv
// Loads the instruction memory over AXI4-Lite writes while holding the core in reset,
// then releases the core with a timed reset/flush tail once HOLD is cleared.
module imem_load_ctrl #(
  parameter logic        BOOT_HOLD    = 1'b1,
  parameter int unsigned RESET_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  imem_load_ctrl_if.slave        bus,
  input  logic                   fetch_en,
  input  logic                   flush_in,
  output logic                   imem_write_en,
  output logic [7:0]             imem_write_addr,
  output logic [31:0]            imem_write_data,
  output logic                   imem_read_en,
  output logic                   imem_flush,
  output logic                   core_rst
);

  localparam logic [3:0] REL_INIT = 4'(RESET_CYCLES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic        hold;
  logic [3:0]  rel_cnt;
  logic [1:0]  bresp;
  logic        hs;

  logic [10:2] lat_addr;
  logic [3:0]  lat_strb;
  logic        lat_d0;

  logic        imem_ok, ctrl_ok, imem_live_ok;
  logic        unused_addr_lsb;

  assign unused_addr_lsb = ^bus.s_awaddr[1:0];

  // Decode of the latched transaction, evaluated during WRITE.
  assign imem_ok      = ~lat_addr[10] & hold & (lat_strb == 4'hF);
  assign ctrl_ok      = lat_addr[10] & (lat_addr[9:2] == 8'd0);
  assign imem_live_ok = ~bus.s_awaddr[10] & hold & (bus.s_wstrb == 4'hF);

  always_comb begin
    state_nxt = state;
    hs        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.s_awvalid && bus.s_wvalid) begin
          hs        = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE:   state_nxt = RESP;
      RESP:    if (bus.s_bready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.s_awready = hs & ~rst;
  assign bus.s_wready  = hs & ~rst;
  assign bus.s_bvalid  = (state == RESP);
  assign bus.s_bresp   = bresp;

  // A reset landing in the WRITE cycle must suppress the strobe in that same cycle.
  assign imem_write_en = (state == WRITE) & imem_ok & ~rst;

  assign core_rst      = hold | (rel_cnt != 4'd0);
  assign imem_read_en  = fetch_en & ~core_rst;
  assign imem_flush    = flush_in | core_rst;

  always_ff @(posedge clk) begin
    if (hs) begin
      lat_addr <= bus.s_awaddr[10:2];
      lat_strb <= bus.s_wstrb;
      lat_d0   <= bus.s_wdata[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      hold            <= BOOT_HOLD;
      rel_cnt         <= 4'd0;
      bresp           <= RESP_OKAY;
      imem_write_addr <= 8'd0;
      imem_write_data <= 32'd0;
    end else begin
      state <= state_nxt;
      // Address/data only move on a write that will actually be performed.
      if (hs && imem_live_ok) begin
        imem_write_addr <= bus.s_awaddr[9:2];
        imem_write_data <= bus.s_wdata;
      end
      if (state == WRITE)
        bresp <= (imem_ok || ctrl_ok) ? RESP_OKAY : RESP_SLVERR;
      if ((state == WRITE) && ctrl_ok && (lat_d0 != hold)) begin
        hold    <= lat_d0;
        rel_cnt <= lat_d0 ? 4'd0 : REL_INIT;
      end else if (!hold && (rel_cnt != 4'd0)) begin
        rel_cnt <= rel_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: load, release tail, error responses, backpressure, abort.
module tb_imem_load_ctrl;
  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        flush_in;
  logic        imem_write_en;
  logic [7:0]  imem_write_addr;
  logic [31:0] imem_write_data;
  logic        imem_read_en;
  logic        imem_flush;
  logic        core_rst;

  int n_checks = 0;
  int n_fail   = 0;

  imem_load_ctrl_if bus ();

  imem_load_ctrl #(.BOOT_HOLD(1'b1), .RESET_CYCLES(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .fetch_en        (fetch_en),
    .flush_in        (flush_in),
    .imem_write_en   (imem_write_en),
    .imem_write_addr (imem_write_addr),
    .imem_write_data (imem_write_data),
    .imem_read_en    (imem_read_en),
    .imem_flush      (imem_flush),
    .core_rst        (core_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present AW+W together; returns whether they were accepted. Leaves time at posedge+1 (WRITE cycle).
  task automatic send(input logic [10:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      output logic accepted);
    @(negedge clk);
    bus.s_awvalid = 1'b1;
    bus.s_wvalid  = 1'b1;
    bus.s_awaddr  = addr;
    bus.s_wdata   = data;
    bus.s_wstrb   = strb;
    #1;
    accepted = bus.s_awready & bus.s_wready;
    @(posedge clk);
    #1;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
  endtask

  // Called while in RESP: accept the response, return at posedge+1 in IDLE.
  task automatic ack;
    bus.s_bready = 1'b1;
    @(posedge clk);
    #1;
    bus.s_bready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    fetch_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL reset_core_rst: got %b want 1", core_rst); end
    n_checks++; if (imem_read_en !== 1'b0) begin n_fail++; $display("FAIL reset_read_en: got %b want 0", imem_read_en); end
    n_checks++; if (imem_flush !== 1'b1) begin n_fail++; $display("FAIL reset_flush: got %b want 1", imem_flush); end
    n_checks++; if (bus.s_bvalid !== 1'b0) begin n_fail++; $display("FAIL reset_bvalid: got %b want 0", bus.s_bvalid); end
    n_checks++; if (bus.s_bresp !== 2'b00) begin n_fail++; $display("FAIL reset_bresp: got %b want 00", bus.s_bresp); end
    n_checks++; if (bus.s_awready !== 1'b0) begin n_fail++; $display("FAIL reset_awready: got %b want 0", bus.s_awready); end
    n_checks++; if (imem_write_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", imem_write_en); end
    n_checks++; if ({imem_write_addr, imem_write_data} !== 40'd0) begin n_fail++; $display("FAIL reset_waddr_wdata: got %h/%h want 0/0", imem_write_addr, imem_write_data); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL boot_hold: got %b want 1", core_rst); end
  endtask

  task automatic test_imem_write;
    logic acc;
    send(11'h004, 32'hDEADBEEF, 4'hF, acc);
    n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL t2_accept: got %b want 1", acc); end
    n_checks++; if (imem_write_en !== 1'b1) begin n_fail++; $display("FAIL t2_wen: got %b want 1", imem_write_en); end
    n_checks++; if (imem_write_addr !== 8'd1) begin n_fail++; $display("FAIL t2_waddr: got %h want 01", imem_write_addr); end
    n_checks++; if (imem_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t2_wdata: got %h want deadbeef", imem_write_data); end
    n_checks++; if (bus.s_bvalid !== 1'b0) begin n_fail++; $display("FAIL t2_bvalid_early: got %b want 0", bus.s_bvalid); end
    @(posedge clk);
    #1;
    n_checks++; if (imem_write_en !== 1'b0) begin n_fail++; $display("FAIL t2_wen_pulse: got %b want 0", imem_write_en); end
    n_checks++; if (bus.s_bvalid !== 1'b1) begin n_fail++; $display("FAIL t2_bvalid: got %b want 1", bus.s_bvalid); end
    n_checks++; if (bus.s_bresp !== 2'b00) begin n_fail++; $display("FAIL t2_bresp: got %b want 00", bus.s_bresp); end
    n_checks++; if (imem_write_addr !== 8'd1) begin n_fail++; $display("FAIL t2_waddr_hold: got %h want 01", imem_write_addr); end
    ack();
    n_checks++; if (bus.s_bvalid !== 1'b0) begin n_fail++; $display("FAIL t2_bvalid_clear: got %b want 0", bus.s_bvalid); end
  endtask

  task automatic test_release;
    logic acc;
    fetch_en = 1'b1;
    send(11'h400, 32'h0, 4'hF, acc);
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL t3_write_cycle_rst: got %b want 1", core_rst); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL t3_tail_rst[%0d]: got %b want 1", k, core_rst); end
      n_checks++; if (imem_flush !== 1'b1) begin n_fail++; $display("FAIL t3_tail_flush[%0d]: got %b want 1", k, imem_flush); end
      n_checks++; if (imem_read_en !== 1'b0) begin n_fail++; $display("FAIL t3_tail_read_en[%0d]: got %b want 0", k, imem_read_en); end
      if (k == 1) begin
        n_checks++; if ({bus.s_bvalid, bus.s_bresp} !== 3'b100) begin n_fail++; $display("FAIL t3_resp: got %b%b want 100", bus.s_bvalid, bus.s_bresp); end
        bus.s_bready = 1'b1;
      end else begin
        bus.s_bready = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    n_checks++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL t3_release: got %b want 0", core_rst); end
    n_checks++; if (imem_read_en !== 1'b1) begin n_fail++; $display("FAIL t3_read_en: got %b want 1", imem_read_en); end
    n_checks++; if (imem_flush !== 1'b0) begin n_fail++; $display("FAIL t3_flush_low: got %b want 0", imem_flush); end
    flush_in = 1'b1;
    #1;
    n_checks++; if (imem_flush !== 1'b1) begin n_fail++; $display("FAIL t3_flush_in: got %b want 1", imem_flush); end
    flush_in = 1'b0;
    fetch_en = 1'b0;
    #1;
    n_checks++; if (imem_read_en !== 1'b0) begin n_fail++; $display("FAIL t3_fetch_off: got %b want 0", imem_read_en); end
    fetch_en = 1'b1;
  endtask

  task automatic test_errors;
    logic acc;
    // HOLD is 0 here: imem write must be refused
    send(11'h008, 32'h12345678, 4'hF, acc);
    n_checks++; if (imem_write_en !== 1'b0) begin n_fail++; $display("FAIL t4_run_wen: got %b want 0", imem_write_en); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.s_bresp !== 2'b10) begin n_fail++; $display("FAIL t4_run_bresp: got %b want 10", bus.s_bresp); end
    n_checks++; if (imem_write_addr !== 8'd1) begin n_fail++; $display("FAIL t4_run_waddr: got %h want 01", imem_write_addr); end
    ack();
    send(11'h400, 32'h1, 4'hF, acc);
    @(posedge clk);
    #1;
    n_checks++; if (bus.s_bresp !== 2'b00) begin n_fail++; $display("FAIL t4_sethold_bresp: got %b want 00", bus.s_bresp); end
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL t4_sethold_rst: got %b want 1", core_rst); end
    ack();
    send(11'h00C, 32'hAAAA5555, 4'h3, acc);
    n_checks++; if (imem_write_en !== 1'b0) begin n_fail++; $display("FAIL t4_strb_wen: got %b want 0", imem_write_en); end
    @(posedge clk);
    #1;
    n_checks++; if (bus.s_bresp !== 2'b10) begin n_fail++; $display("FAIL t4_strb_bresp: got %b want 10", bus.s_bresp); end
    ack();
    send(11'h404, 32'h0, 4'hF, acc);
    @(posedge clk);
    #1;
    n_checks++; if (bus.s_bresp !== 2'b10) begin n_fail++; $display("FAIL t4_ctrl_off_bresp: got %b want 10", bus.s_bresp); end
    ack();
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL t4_ctrl_off_hold: got %b want 1", core_rst); end
  endtask

  task automatic test_back_to_back;
    logic acc;
    send(11'h010, 32'h11112222, 4'hF, acc);
    @(posedge clk);
    #1;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid  = 1'b1;
    bus.s_awaddr  = 11'h014;
    bus.s_wdata   = 32'h33334444;
    bus.s_wstrb   = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      n_checks++; if ({bus.s_bvalid, bus.s_bresp} !== 3'b100) begin n_fail++; $display("FAIL t5_resp_held[%0d]: got %b%b want 100", k, bus.s_bvalid, bus.s_bresp); end
      n_checks++; if ({bus.s_awready, bus.s_wready} !== 2'b00) begin n_fail++; $display("FAIL t5_ready_blocked[%0d]: got %b%b want 00", k, bus.s_awready, bus.s_wready); end
      @(posedge clk);
      #1;
    end
    bus.s_bready = 1'b1;
    #1;
    n_checks++; if (bus.s_awready !== 1'b0) begin n_fail++; $display("FAIL t5_ready_during_b: got %b want 0", bus.s_awready); end
    @(posedge clk);
    #1;
    bus.s_bready = 1'b0;
    n_checks++; if ({bus.s_awready, bus.s_wready} !== 2'b11) begin n_fail++; $display("FAIL t5_ready_after_b: got %b%b want 11", bus.s_awready, bus.s_wready); end
    @(posedge clk);
    #1;
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    n_checks++; if (imem_write_en !== 1'b1) begin n_fail++; $display("FAIL t5_second_wen: got %b want 1", imem_write_en); end
    n_checks++; if (imem_write_addr !== 8'd5) begin n_fail++; $display("FAIL t5_second_waddr: got %h want 05", imem_write_addr); end
    n_checks++; if (imem_write_data !== 32'h33334444) begin n_fail++; $display("FAIL t5_second_wdata: got %h want 33334444", imem_write_data); end
    @(posedge clk);
    #1;
    ack();
  endtask

  task automatic test_abort;
    logic acc;
    send(11'h018, 32'h55555555, 4'hF, acc);
    rst = 1'b1;
    #1;
    n_checks++; if (imem_write_en !== 1'b0) begin n_fail++; $display("FAIL t6_abort_wen: got %b want 0", imem_write_en); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (bus.s_bvalid !== 1'b0) begin n_fail++; $display("FAIL t6_abort_bvalid[%0d]: got %b want 0", k, bus.s_bvalid); end
      @(posedge clk);
      #1;
    end
    n_checks++; if (imem_write_addr !== 8'd0) begin n_fail++; $display("FAIL t6_abort_waddr: got %h want 00", imem_write_addr); end
    send(11'h400, 32'h0, 4'hF, acc);
    @(posedge clk);
    #1;
    ack();
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (core_rst !== 1'b0) begin n_fail++; $display("FAIL t6_released: got %b want 0", core_rst); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL t6_hold_restored: got %b want 1", core_rst); end
    // Address without data must never be taken.
    bus.s_awvalid = 1'b1;
    bus.s_awaddr  = 11'h01C;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (bus.s_awready !== 1'b0) begin n_fail++; $display("FAIL t6_aw_only_ready[%0d]: got %b want 0", k, bus.s_awready); end
      @(posedge clk);
      #1;
      n_checks++; if ((imem_write_en | bus.s_bvalid) !== 1'b0) begin n_fail++; $display("FAIL t6_aw_only_activity[%0d]: got wen=%b bvalid=%b want 0/0", k, imem_write_en, bus.s_bvalid); end
    end
    bus.s_awvalid = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    fetch_en      = 1'b0;
    flush_in      = 1'b0;
    bus.s_awvalid = 1'b0;
    bus.s_awaddr  = 11'h0;
    bus.s_wvalid  = 1'b0;
    bus.s_wdata   = 32'h0;
    bus.s_wstrb   = 4'h0;
    bus.s_bready  = 1'b0;
    test_reset();
    test_imem_write();
    test_release();
    test_errors();
    test_back_to_back();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
